// File: rtl/eth_axis_rx_arbiter.sv
// Packet-level round-robin merge of several Ethernet RX AXI-Stream channels
// into one tagged stream, with a per-packet stall watchdog.
module eth_axis_rx_arbiter #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 1,
    parameter int TIMEOUT    = 1024
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [CHANNELS-1:0]            enable,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [CHANNELS-1:0]            s_axis_tlast,
    input  logic [CHANNELS-1:0]            s_axis_tuser,
    input  logic [CHANNELS-1:0]            s_axis_tvalid,
    output logic [CHANNELS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic [ID_WIDTH-1:0]            m_axis_tid,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           busy,
    output logic                           abort_pulse
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        DROP
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
    logic                  m_last_q, m_last_d;
    logic                  m_user_q, m_user_d;
    logic [ID_WIDTH-1:0]   m_id_q, m_id_d;
    logic                  m_valid_q, m_valid_d;
    logic                  abort_q, abort_d;

    logic [CHANNELS-1:0]   req;
    logic                  arb_found;
    logic [ID_WIDTH-1:0]   arb_grant;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_user;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic                  load_ok;
    logic                  grant_ready;

    assign load_ok = !m_valid_q || m_axis_tready;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    // Search starts just above the previous winner and wraps around.
    always_comb begin
        req       = s_axis_tvalid & enable;
        arb_found = 1'b0;
        arb_grant = last_grant_q;
        for (int k = 1; k <= CHANNELS; k++) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!arb_found && req[i] &&
                    i == (int'(last_grant_q) + k) % CHANNELS) begin
                    arb_found = 1'b1;
                    arb_grant = ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        abort_d      = 1'b0;
        grant_ready  = 1'b0;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        m_user_d     = m_user_q;
        m_id_d       = m_id_q;
        m_valid_d    = load_ok ? 1'b0 : m_valid_q;

        unique case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    cnt_d        = '0;
                    state_d      = PASS;
                end
            end
            PASS: begin
                grant_ready = load_ok;
                if (sel_valid) begin
                    if (load_ok) begin
                        m_data_d  = sel_data;
                        m_keep_d  = sel_keep;
                        m_last_d  = sel_last;
                        m_user_d  = sel_user;
                        m_id_d    = grant_q;
                        m_valid_d = 1'b1;
                        cnt_d     = '0;
                        if (sel_last) begin
                            state_d = IDLE;
                        end
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT)) begin
                    // Abort waits for a free output slot; it is never dropped.
                    if (load_ok) begin
                        m_data_d  = '0;
                        m_keep_d  = KEEP_WIDTH'(1);
                        m_last_d  = 1'b1;
                        m_user_d  = 1'b1;
                        m_id_d    = grant_q;
                        m_valid_d = 1'b1;
                        abort_d   = 1'b1;
                        state_d   = DROP;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DROP: begin
                grant_ready = 1'b1;
                if (sel_valid && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            s_axis_tready[i] = grant_ready && (grant_q == ID_WIDTH'(i));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(CHANNELS - 1);
            cnt_q        <= '0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_user_q     <= 1'b0;
            m_id_q       <= '0;
            m_valid_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_user_q     <= m_user_d;
            m_id_q       <= m_id_d;
            m_valid_q    <= m_valid_d;
            abort_q      <= abort_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tid    = m_id_q;
    assign m_axis_tvalid = m_valid_q;
    assign busy          = (state_q != IDLE);
    assign abort_pulse   = abort_q;

endmodule

// File: tb/tb_eth_axis_rx_arbiter.sv
// Directed bench for eth_axis_rx_arbiter: two channels, watchdog of 8 cycles.
module tb_eth_axis_rx_arbiter;

    localparam int CH = 2;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int IW = 1;
    localparam int TO = 8;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic [CH-1:0]    enable = '1;
    logic [CH*DW-1:0] s_axis_tdata = '0;
    logic [CH*KW-1:0] s_axis_tkeep = '0;
    logic [CH-1:0]    s_axis_tlast = '0;
    logic [CH-1:0]    s_axis_tuser = '0;
    logic [CH-1:0]    s_axis_tvalid = '0;
    logic [CH-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tlast;
    logic             m_axis_tuser;
    logic [IW-1:0]    m_axis_tid;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             busy;
    logic             abort_pulse;

    eth_axis_rx_arbiter #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .ID_WIDTH(IW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .resetn(resetn), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tid(m_axis_tid), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .busy(busy),
        .abort_pulse(abort_pulse)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    typedef struct {
        beat_t         b;
        logic [IW-1:0] tid;
        int            cyc;
    } mbeat_t;

    beat_t  q0[$];
    beat_t  q1[$];
    mbeat_t mon[$];
    beat_t  exp_b[$];
    logic [IW-1:0] exp_t[$];

    int   cyc = 0;
    int   acc0 = 0;
    int   acc1 = 0;
    int   pulses = 0;
    int   pulse_cyc = 0;
    int   npass = 0;
    int   ntotal = 0;
    logic hold0 = 1'b0;
    logic hold1 = 1'b0;
    logic mrdy = 1'b1;

    function automatic beat_t mk(int ch, int pkt, int bt, bit last);
        beat_t b;
        b.data = {16'hD0D0, 16'(ch), 16'(pkt), 16'(bt)};
        b.keep = last ? 8'h0F : 8'hFF;
        b.last = last;
        b.user = last && (ch == 1);
        return b;
    endfunction

    task automatic push(int ch, int pkt, int n);
        for (int bt = 0; bt < n; bt++) begin
            if (ch == 0) q0.push_back(mk(ch, pkt, bt, bt == n - 1));
            else q1.push_back(mk(ch, pkt, bt, bt == n - 1));
        end
    endtask

    task automatic expect_pkt(int ch, int pkt, int n);
        for (int bt = 0; bt < n; bt++) begin
            exp_b.push_back(mk(ch, pkt, bt, bt == n - 1));
            exp_t.push_back(IW'(ch));
        end
    endtask

    // One clock: drive before the edge, then sample what the edge will see.
    task automatic step();
        mbeat_t m;
        beat_t  d;
        @(negedge clock);
        cyc++;
        s_axis_tvalid[0] = !hold0 && q0.size() > 0;
        s_axis_tvalid[1] = !hold1 && q1.size() > 0;
        if (q0.size() > 0) begin
            s_axis_tdata[0 +: DW] = q0[0].data;
            s_axis_tkeep[0 +: KW] = q0[0].keep;
            s_axis_tlast[0] = q0[0].last;
            s_axis_tuser[0] = q0[0].user;
        end
        if (q1.size() > 0) begin
            s_axis_tdata[DW +: DW] = q1[0].data;
            s_axis_tkeep[KW +: KW] = q1[0].keep;
            s_axis_tlast[1] = q1[0].last;
            s_axis_tuser[1] = q1[0].user;
        end
        m_axis_tready = mrdy;
        #1;
        if (abort_pulse) begin
            pulses++;
            pulse_cyc = cyc;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            m.b = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            m.tid = m_axis_tid;
            m.cyc = cyc;
            mon.push_back(m);
        end
        if (s_axis_tvalid[0] && s_axis_tready[0]) begin
            d = q0.pop_front();
            acc0++;
        end
        if (s_axis_tvalid[1] && s_axis_tready[1]) begin
            d = q1.pop_front();
            acc1++;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        q0.delete();
        q1.delete();
        mon.delete();
        exp_b.delete();
        exp_t.delete();
        hold0 = 1'b0;
        hold1 = 1'b0;
        mrdy = 1'b1;
        enable = 2'b11;
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        acc0 = 0;
        acc1 = 0;
        pulses = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clock);
        #1;
        ntotal++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
             busy, abort_pulse, s_axis_tready} !== '0)
            $display("FAIL reset_ctrl: got %b expected 0",
                     {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
                      busy, abort_pulse, s_axis_tready});
        else npass++;
        ntotal++;
        if ({m_axis_tdata, m_axis_tkeep} !== '0)
            $display("FAIL reset_data: got %h expected 0",
                     {m_axis_tdata, m_axis_tkeep});
        else npass++;
    endtask

    task automatic test_single_packet();
        int start;
        do_reset();
        push(0, 0, 4);
        expect_pkt(0, 0, 4);
        start = cyc + 1;
        for (int k = 0; k < 30 && mon.size() < 4; k++) step();
        ntotal++;
        if (mon.size() != 4)
            $display("FAIL single_count: got %0d expected 4", mon.size());
        else npass++;
        for (int i = 0; i < 4 && i < mon.size(); i++) begin
            ntotal++;
            if (mon[i].b !== exp_b[i] || mon[i].tid !== exp_t[i] ||
                mon[i].cyc != start + 2 + i)
                $display("FAIL single_beat%0d: got %h/%0d@%0d expected %h/%0d@%0d",
                         i, mon[i].b, mon[i].tid, mon[i].cyc,
                         exp_b[i], exp_t[i], start + 2 + i);
            else npass++;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            push(0, p, 2);
            push(1, p, 2);
            expect_pkt(0, p, 2);
            expect_pkt(1, p, 2);
        end
        for (int k = 0; k < 100 && mon.size() < 12; k++) step();
        ntotal++;
        if (mon.size() != 12)
            $display("FAIL rr_count: got %0d expected 12", mon.size());
        else npass++;
        for (int i = 0; i < 12 && i < mon.size(); i++) begin
            ntotal++;
            if (mon[i].b !== exp_b[i] || mon[i].tid !== exp_t[i])
                $display("FAIL rr_beat%0d: got %h/%0d expected %h/%0d",
                         i, mon[i].b, mon[i].tid, exp_b[i], exp_t[i]);
            else npass++;
        end
    endtask

    task automatic test_backpressure();
        logic          pv;
        logic          pr;
        logic [DW-1:0] pd;
        logic          pl;
        do_reset();
        push(0, 7, 5);
        expect_pkt(0, 7, 5);
        for (int k = 0; k < 60 && mon.size() < 5; k++) begin
            pv = m_axis_tvalid;
            pr = m_axis_tready;
            pd = m_axis_tdata;
            pl = m_axis_tlast;
            mrdy = (k % 2 == 0);
            step();
            if (pv && !pr) begin
                ntotal++;
                if (!m_axis_tvalid || m_axis_tdata !== pd || m_axis_tlast !== pl)
                    $display("FAIL bp_hold: got %b/%h expected 1/%h",
                             m_axis_tvalid, m_axis_tdata, pd);
                else npass++;
            end
            if (m_axis_tvalid && !m_axis_tready) begin
                ntotal++;
                if (s_axis_tready !== 2'b00)
                    $display("FAIL bp_sready: got %b expected 00", s_axis_tready);
                else npass++;
            end
        end
        mrdy = 1'b1;
        ntotal++;
        if (mon.size() != 5)
            $display("FAIL bp_count: got %0d expected 5", mon.size());
        else npass++;
        for (int i = 0; i < 5 && i < mon.size(); i++) begin
            ntotal++;
            if (mon[i].b !== exp_b[i] || mon[i].tid !== exp_t[i])
                $display("FAIL bp_beat%0d: got %h/%0d expected %h/%0d",
                         i, mon[i].b, mon[i].tid, exp_b[i], exp_t[i]);
            else npass++;
        end
    endtask

    task automatic test_watchdog();
        beat_t ab;
        int    after;
        bit    released;
        after = 0;
        released = 0;
        ab = {64'h0, 8'h01, 1'b1, 1'b1};
        do_reset();
        push(1, 9, 5);
        for (int k = 0; k < 200 && !(released && mon.size() >= 5 &&
                                    q0.size() == 0); k++) begin
            step();
            if (acc1 == 2 && !hold1 && !released) hold1 = 1'b1;
            if (pulses > 0 && !released) begin
                after++;
                if (after == 3) begin
                    hold1 = 1'b0;
                    released = 1;
                    push(0, 3, 2);
                end
            end
        end
        for (int k = 0; k < 5; k++) step();
        ntotal++;
        if (pulses != 1)
            $display("FAIL wd_pulses: got %0d expected 1", pulses);
        else npass++;
        ntotal++;
        if (mon.size() != 5)
            $display("FAIL wd_count: got %0d expected 5", mon.size());
        else npass++;
        if (mon.size() == 5) begin
            for (int i = 0; i < 2; i++) begin
                ntotal++;
                if (mon[i].b !== mk(1, 9, i, 0) || mon[i].tid !== 1'b1)
                    $display("FAIL wd_head%0d: got %h/%0d expected %h/1",
                             i, mon[i].b, mon[i].tid, mk(1, 9, i, 0));
                else npass++;
            end
            ntotal++;
            if (mon[2].b !== ab || mon[2].tid !== 1'b1)
                $display("FAIL wd_abort_beat: got %h/%0d expected %h/1",
                         mon[2].b, mon[2].tid, ab);
            else npass++;
            ntotal++;
            if (mon[2].cyc - mon[1].cyc != TO + 1 || pulse_cyc != mon[2].cyc)
                $display("FAIL wd_timing: got %0d,%0d expected %0d,%0d",
                         mon[2].cyc - mon[1].cyc, pulse_cyc, TO + 1, mon[2].cyc);
            else npass++;
            for (int i = 0; i < 2; i++) begin
                ntotal++;
                if (mon[3+i].b !== mk(0, 3, i, i == 1) || mon[3+i].tid !== 1'b0)
                    $display("FAIL wd_next%0d: got %h/%0d expected %h/0",
                             i, mon[3+i].b, mon[3+i].tid, mk(0, 3, i, i == 1));
                else npass++;
            end
        end
        ntotal++;
        if (acc1 != 5 || busy !== 1'b0)
            $display("FAIL wd_drain: got %0d/%b expected 5/0", acc1, busy);
        else npass++;
    endtask

    task automatic test_enable();
        do_reset();
        enable = 2'b01;
        push(0, 0, 2);
        push(0, 1, 2);
        push(1, 0, 2);
        expect_pkt(0, 0, 2);
        expect_pkt(0, 1, 2);
        expect_pkt(1, 0, 2);
        for (int k = 0; k < 60 && mon.size() < 6; k++) begin
            step();
            if (acc0 == 3) enable = 2'b11;
        end
        ntotal++;
        if (mon.size() != 6)
            $display("FAIL en_count: got %0d expected 6", mon.size());
        else npass++;
        for (int i = 0; i < 6 && i < mon.size(); i++) begin
            ntotal++;
            if (mon[i].b !== exp_b[i] || mon[i].tid !== exp_t[i])
                $display("FAIL en_beat%0d: got %h/%0d expected %h/%0d",
                         i, mon[i].b, mon[i].tid, exp_b[i], exp_t[i]);
            else npass++;
        end
    endtask

    task automatic test_reset_mid();
        int start;
        do_reset();
        push(0, 5, 4);
        for (int k = 0; k < 30 && mon.size() < 2; k++) step();
        resetn = 1'b0;
        #1;
        ntotal++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
             busy, abort_pulse, s_axis_tready} !== '0)
            $display("FAIL rmid_ctrl: got %b expected 0",
                     {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid,
                      busy, abort_pulse, s_axis_tready});
        else npass++;
        ntotal++;
        if ({m_axis_tdata, m_axis_tkeep} !== '0)
            $display("FAIL rmid_data: got %h expected 0",
                     {m_axis_tdata, m_axis_tkeep});
        else npass++;
        q0.delete();
        mon.delete();
        s_axis_tvalid = '0;
        @(negedge clock);
        resetn = 1'b1;
        step();
        ntotal++;
        if (busy !== 1'b0)
            $display("FAIL rmid_idle: got %b expected 0", busy);
        else npass++;
        push(1, 6, 2);
        start = cyc + 1;
        for (int k = 0; k < 30 && mon.size() < 2; k++) step();
        ntotal++;
        if (mon.size() < 1 || mon[0].cyc != start + 2 ||
            mon[0].b !== mk(1, 6, 0, 0) || mon[0].tid !== 1'b1)
            $display("FAIL rmid_regrant: got %0d beats expected first at %0d",
                     mon.size(), start + 2);
        else npass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_watchdog();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
